// File: rtl/neopixel_multi_controller.sv
// Multi-channel NeoPixel (WS281x/SK6812) serializer.
// All channels share one slot timer and shift their own pixel word MSB first,
// so every data line toggles on the same slot boundaries.
module neopixel_multi_controller #(
  parameter int NumChannels   = 4,
  parameter int CounterWidth  = 16,
  parameter int NumPixelWidth = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          rgbw_i,
  input  logic [NumPixelWidth-1:0]      num_pixel_i,
  input  logic [CounterWidth-1:0]       t1h_i,
  input  logic [CounterWidth-1:0]       t1l_i,
  input  logic [CounterWidth-1:0]       t0h_i,
  input  logic [CounterWidth-1:0]       t0l_i,
  input  logic [CounterWidth-1:0]       t_latch_i,
  input  logic [CounterWidth-1:0]       sleep_i,
  input  logic [NumChannels-1:0][31:0]  data_i,
  input  logic [NumChannels-1:0]        valid_i,
  output logic [NumChannels-1:0]        ready_o,
  output logic [NumChannels-1:0]        data_o,
  output logic                          busy_o,
  output logic [NumChannels-1:0]        underrun_o,
  output logic                          frame_done_o
);

  // One extra bit so the slot length (sum of two timing fields) never overflows.
  localparam int SlotWidth = CounterWidth + 1;

  typedef enum logic [1:0] {IDLE, SEND, LATCH, SLEEP} state_t;

  state_t state, state_next;

  logic [SlotWidth-1:0]             cnt;
  logic [4:0]                       bit_idx;
  logic [NumPixelWidth-1:0]         pix_idx;
  logic [NumChannels-1:0][31:0]     shift;
  logic [NumChannels-1:0]           underrun;
  logic                             frame_done;

  // Frame configuration captured at frame start.
  logic                             rgbw;
  logic [NumPixelWidth-1:0]         num_pixel;
  logic [CounterWidth-1:0]          t1h, t1l, t0h, t0l, t_latch, sleep;

  logic [SlotWidth-1:0]             one_len, zero_len, slot_len, slot_last;
  logic [SlotWidth-1:0]             latch_last, sleep_last;
  logic                             start, slot_end, bit_last, pix_last;
  logic                             load_first, load_next;

  assign one_len    = {1'b0, t1h} + {1'b0, t1l};
  assign zero_len   = {1'b0, t0h} + {1'b0, t0l};
  assign slot_last  = slot_len - SlotWidth'(1);
  assign latch_last = (t_latch == '0) ? '0 : ({1'b0, t_latch} - SlotWidth'(1));
  assign sleep_last = {1'b0, sleep} - SlotWidth'(1);

  // Start is gated by reset so no pop strobe can leak out while reset is held.
  assign start    = rst_ni && enable_i && (num_pixel_i != '0) && (&valid_i);
  assign slot_end = (cnt == slot_last);
  assign bit_last = (bit_idx == (rgbw ? 5'd31 : 5'd23));
  assign pix_last = (pix_idx == (num_pixel - NumPixelWidth'(1)));

  assign underrun_o   = underrun;
  assign frame_done_o = frame_done;

  // Slot length is the longer of the two bit types; a zero-length slot still takes one cycle.
  always_comb begin
    slot_len = (one_len > zero_len) ? one_len : zero_len;
    if (slot_len == '0) begin
      slot_len = SlotWidth'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the pop strobes, busy flag and serial outputs.
  always_comb begin
    state_next = state;
    ready_o    = '0;
    data_o     = '0;
    busy_o     = (state != IDLE);
    load_first = 1'b0;
    load_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ready_o    = '1;
          load_first = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        for (int c = 0; c < NumChannels; c++) begin
          data_o[c] = (cnt < {1'b0, (shift[c][31] ? t1h : t0h)});
        end
        if (slot_end && bit_last) begin
          if (pix_last) begin
            state_next = LATCH;
          end else begin
            ready_o   = '1;
            load_next = 1'b1;
          end
        end
      end
      LATCH: begin
        if (cnt == latch_last) begin
          state_next = (sleep != '0) ? SLEEP : IDLE;
        end
      end
      SLEEP: begin
        if (cnt == sleep_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: config snapshot, slot/bit/pixel counters, shift words and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt        <= '0;
      bit_idx    <= '0;
      pix_idx    <= '0;
      shift      <= '0;
      underrun   <= '0;
      frame_done <= 1'b0;
      rgbw       <= 1'b0;
      num_pixel  <= '0;
      t1h        <= '0;
      t1l        <= '0;
      t0h        <= '0;
      t0l        <= '0;
      t_latch    <= '0;
      sleep      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (load_first) begin
        cnt       <= '0;
        bit_idx   <= '0;
        pix_idx   <= '0;
        shift     <= data_i;
        underrun  <= '0;
        rgbw      <= rgbw_i;
        num_pixel <= num_pixel_i;
        t1h       <= t1h_i;
        t1l       <= t1l_i;
        t0h       <= t0h_i;
        t0l       <= t0l_i;
        t_latch   <= t_latch_i;
        sleep     <= sleep_i;
      end else begin
        unique case (state)
          SEND: begin
            if (slot_end) begin
              cnt <= '0;
              for (int c = 0; c < NumChannels; c++) begin
                shift[c] <= {shift[c][30:0], 1'b0};
              end
              if (bit_last) begin
                bit_idx <= '0;
                if (load_next) begin
                  pix_idx  <= pix_idx + NumPixelWidth'(1);
                  underrun <= underrun | ~valid_i;
                  for (int c = 0; c < NumChannels; c++) begin
                    shift[c] <= valid_i[c] ? data_i[c] : 32'd0;
                  end
                end
              end else begin
                bit_idx <= bit_idx + 5'd1;
              end
            end else begin
              cnt <= cnt + SlotWidth'(1);
            end
          end
          LATCH: begin
            if (cnt == latch_last) begin
              cnt        <= '0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + SlotWidth'(1);
            end
          end
          SLEEP: begin
            if (cnt == sleep_last) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + SlotWidth'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neopixel_multi_controller.sv
// Self-checking bench for neopixel_multi_controller with two channels.
module tb_neopixel_multi_controller;

  localparam int NCh = 2;
  localparam int CW  = 16;
  localparam int NPW = 12;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   enable_i = 1'b0;
  logic                   rgbw_i = 1'b0;
  logic [NPW-1:0]         num_pixel_i = '0;
  logic [CW-1:0]          t1h_i = '0, t1l_i = '0, t0h_i = '0, t0l_i = '0;
  logic [CW-1:0]          t_latch_i = '0, sleep_i = '0;
  logic [NCh-1:0][31:0]   data_i = '0;
  logic [NCh-1:0]         valid_i = '0;
  logic [NCh-1:0]         ready_o, data_o, underrun_o;
  logic                   busy_o, frame_done_o;

  int compared = 0;
  int mismatched = 0;

  neopixel_multi_controller #(
    .NumChannels(NCh), .CounterWidth(CW), .NumPixelWidth(NPW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .rgbw_i(rgbw_i),
    .num_pixel_i(num_pixel_i), .t1h_i(t1h_i), .t1l_i(t1l_i), .t0h_i(t0h_i),
    .t0l_i(t0l_i), .t_latch_i(t_latch_i), .sleep_i(sleep_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .busy_o(busy_o),
    .underrun_o(underrun_o), .frame_done_o(frame_done_o)
  );

  // 10-time-unit clock.
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rgbw;
    int          npix;
    int          t1h, t1l, t0h, t0l, tlatch, sleep;
    logic [31:0] w0, w1;
    logic [1:0]  valid_after;
    logic        scramble;
    int          slot_len;
    int          frame_len;
    int          high0, high1;
    int          pops0, pops1;
    logic [1:0]  exp_underrun;
  } vec_t;

  vec_t vecs[6];
  int   slot_high[2][0:127];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int id);
    int   bits, send_len, busy_cnt, sleep_cnt, done_cnt, latch_high, pops0, pops1;
    int   tot0, tot1, idle_bad, p, i, exp_high;
    logic done_seen, finished, b;
    logic [31:0] word;
    bits       = v.rgbw ? 32 : 24;
    send_len   = v.npix * bits * v.slot_len;
    busy_cnt   = 0;
    sleep_cnt  = 0;
    done_cnt   = 0;
    latch_high = 0;
    done_seen  = 1'b0;
    finished   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 128; j++) slot_high[c][j] = 0;
    end

    @(negedge clk_i);
    rgbw_i      = v.rgbw;
    num_pixel_i = NPW'(v.npix);
    t1h_i       = CW'(v.t1h);
    t1l_i       = CW'(v.t1l);
    t0h_i       = CW'(v.t0h);
    t0l_i       = CW'(v.t0l);
    t_latch_i   = CW'(v.tlatch);
    sleep_i     = CW'(v.sleep);
    data_i[0]   = v.w0;
    data_i[1]   = v.w1;
    valid_i     = 2'b11;
    enable_i    = 1'b1;
    #1;
    checkOutput($sformatf("v%0d start ready", id), ready_o, 2'b11);
    checkOutput($sformatf("v%0d start busy", id), busy_o, 0);
    pops0 = int'(ready_o[0] & valid_i[0]);
    pops1 = int'(ready_o[1] & valid_i[1]);

    // Change inputs only after the start edge has taken the snapshot.
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    valid_i  = v.valid_after;
    if (v.scramble) begin
      t1h_i       = CW'(v.t1h + 3);
      t0h_i       = '0;
      num_pixel_i = NPW'(v.npix + 2);
      rgbw_i      = ~v.rgbw;
      t_latch_i   = CW'(7);
      sleep_i     = CW'(9);
    end

    for (int cyc = 0; cyc < send_len + v.tlatch + v.sleep + 40; cyc++) begin
      @(negedge clk_i);
      if (cyc == 0) checkOutput($sformatf("v%0d underrun cleared", id), underrun_o, 0);
      pops0 += int'(ready_o[0] & valid_i[0]);
      pops1 += int'(ready_o[1] & valid_i[1]);
      if (frame_done_o) begin
        done_cnt++;
        done_seen = 1'b1;
      end
      if (!done_seen) begin
        if (busy_o) begin
          if (busy_cnt < send_len) begin
            for (int c = 0; c < 2; c++) slot_high[c][busy_cnt / v.slot_len] += int'(data_o[c]);
          end else begin
            latch_high += int'(data_o != 0);
          end
          busy_cnt++;
        end
      end else begin
        if (busy_o) begin
          sleep_cnt++;
          latch_high += int'(data_o != 0);
        end else begin
          finished = 1'b1;
          break;
        end
      end
    end

    checkOutput($sformatf("v%0d frame finished in budget", id), finished, 1);
    checkOutput($sformatf("v%0d send+latch cycles", id), busy_cnt, v.frame_len);
    checkOutput($sformatf("v%0d sleep cycles", id), sleep_cnt, v.sleep);
    checkOutput($sformatf("v%0d frame_done pulses", id), done_cnt, 1);
    checkOutput($sformatf("v%0d high in latch/sleep", id), latch_high, 0);
    checkOutput($sformatf("v%0d pops ch0", id), pops0, v.pops0);
    checkOutput($sformatf("v%0d pops ch1", id), pops1, v.pops1);
    checkOutput($sformatf("v%0d underrun", id), underrun_o, v.exp_underrun);

    tot0 = 0;
    tot1 = 0;
    for (int j = 0; j < v.npix * bits; j++) begin
      for (int c = 0; c < 2; c++) begin
        word = (c == 0) ? v.w0 : v.w1;
        p = j / bits;
        i = j % bits;
        b = word[31 - i];
        if (p > 0 && !v.valid_after[c]) b = 1'b0;
        exp_high = b ? v.t1h : v.t0h;
        checkOutput($sformatf("v%0d ch%0d slot%0d high", id, c, j), slot_high[c][j], exp_high);
        if (c == 0) tot0 += slot_high[c][j];
        else tot1 += slot_high[c][j];
      end
    end
    checkOutput($sformatf("v%0d total high ch0", id), tot0, v.high0);
    checkOutput($sformatf("v%0d total high ch1", id), tot1, v.high1);

    idle_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (busy_o || frame_done_o || ready_o != 0 || data_o != 0) idle_bad++;
    end
    checkOutput($sformatf("v%0d quiet idle", id), idle_bad, 0);
  endtask

  initial begin
    int bad, sleep_busy;
    logic done_seen, idle_seen;
    logic [1:0] idle_ready;

    // rgbw npix t1h t1l t0h t0l latch sleep  -> slot, frame, highs, pops, underrun
    vecs[0] = '{rgbw:1'b0, npix:1, t1h:8, t1l:4, t0h:4, t0l:8, tlatch:50, sleep:0,
                w0:32'hFF000000, w1:32'h00000000, valid_after:2'b11, scramble:1'b1,
                slot_len:12, frame_len:338, high0:128, high1:96, pops0:1, pops1:1, exp_underrun:2'b00};
    vecs[1] = '{rgbw:1'b1, npix:2, t1h:6, t1l:3, t0h:2, t0l:5, tlatch:10, sleep:0,
                w0:32'h000000FF, w1:32'h000000FF, valid_after:2'b11, scramble:1'b0,
                slot_len:9, frame_len:586, high0:192, high1:192, pops0:2, pops1:2, exp_underrun:2'b00};
    vecs[2] = '{rgbw:1'b0, npix:1, t1h:0, t1l:5, t0h:3, t0l:0, tlatch:0, sleep:3,
                w0:32'hAAAAAAFF, w1:32'h0F0F0F00, valid_after:2'b11, scramble:1'b0,
                slot_len:5, frame_len:121, high0:36, high1:36, pops0:1, pops1:1, exp_underrun:2'b00};
    vecs[3] = '{rgbw:1'b0, npix:2, t1h:2, t1l:1, t0h:1, t0l:2, tlatch:1, sleep:0,
                w0:32'hFFFFFF00, w1:32'hFFFFFF00, valid_after:2'b01, scramble:1'b0,
                slot_len:3, frame_len:145, high0:96, high1:72, pops0:2, pops1:1, exp_underrun:2'b10};
    vecs[4] = '{rgbw:1'b0, npix:3, t1h:0, t1l:0, t0h:0, t0l:0, tlatch:2, sleep:0,
                w0:32'hFFFFFF00, w1:32'h00000000, valid_after:2'b11, scramble:1'b0,
                slot_len:1, frame_len:74, high0:0, high1:0, pops0:3, pops1:3, exp_underrun:2'b00};
    vecs[5] = '{rgbw:1'b1, npix:3, t1h:3, t1l:1, t0h:1, t0l:2, tlatch:5, sleep:7,
                w0:32'h80000001, w1:32'h12345678, valid_after:2'b11, scramble:1'b0,
                slot_len:4, frame_len:389, high0:108, high1:174, pops0:3, pops1:3, exp_underrun:2'b00};

    // Outputs stay low under reset even with a complete start condition present.
    enable_i    = 1'b1;
    valid_i     = 2'b11;
    num_pixel_i = NPW'(1);
    t1h_i       = CW'(2);
    t0h_i       = CW'(1);
    #2;
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset ready", ready_o, 0);
    checkOutput("reset data", data_o, 0);
    checkOutput("reset underrun", underrun_o, 0);
    checkOutput("reset frame_done", frame_done_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("reset held busy", busy_o, 0);
    enable_i = 1'b0;
    rst_ni   = 1'b1;
    @(negedge clk_i);
    checkOutput("post reset busy", busy_o, 0);

    for (int v = 0; v < 6; v++) applyStimulus(vecs[v], v);

    // A zero pixel count must never start a frame.
    @(negedge clk_i);
    num_pixel_i = '0;
    enable_i    = 1'b1;
    valid_i     = 2'b11;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (busy_o || ready_o != 0) bad++;
    end
    checkOutput("npix0 stays idle", bad, 0);
    enable_i = 1'b0;

    // Back-to-back frames through SLEEP, then a reset in the middle of a slot.
    @(negedge clk_i);
    rgbw_i      = 1'b0;
    num_pixel_i = NPW'(1);
    t1h_i       = CW'(1);
    t1l_i       = CW'(1);
    t0h_i       = CW'(1);
    t0l_i       = CW'(1);
    t_latch_i   = CW'(2);
    sleep_i     = CW'(20);
    data_i[0]   = 32'hFFFFFF00;
    data_i[1]   = 32'hFFFFFF00;
    valid_i     = 2'b11;
    enable_i    = 1'b1;
    #1;
    checkOutput("sleep seq start ready", ready_o, 2'b11);
    done_seen  = 1'b0;
    idle_seen  = 1'b0;
    sleep_busy = 0;
    idle_ready = 2'b00;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_i);
      if (frame_done_o) done_seen = 1'b1;
      if (done_seen) begin
        if (busy_o) sleep_busy++;
        else begin
          idle_seen  = 1'b1;
          idle_ready = ready_o;
          break;
        end
      end
    end
    checkOutput("sleep seq reached idle", idle_seen, 1);
    checkOutput("sleep seq busy cycles", sleep_busy, 20);
    checkOutput("sleep seq restart ready", idle_ready, 2'b11);
    @(negedge clk_i);
    checkOutput("restart busy", busy_o, 1);
    checkOutput("restart data high", data_o, 2'b11);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid-slot reset busy", busy_o, 0);
    checkOutput("mid-slot reset data", data_o, 0);
    checkOutput("mid-slot reset ready", ready_o, 0);
    checkOutput("mid-slot reset underrun", underrun_o, 0);
    checkOutput("mid-slot reset frame_done", frame_done_o, 0);
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (busy_o || ready_o != 0 || data_o != 0) bad++;
    end
    checkOutput("idle after reset", bad, 0);
    enable_i = 1'b1;
    #1;
    checkOutput("start after reset ready", ready_o, 2'b11);
    @(negedge clk_i);
    checkOutput("start after reset busy", busy_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/neopixel_multi_controller.md
NEOPIXEL_MULTI_CONTROLLER -- requirements
Module: neopixel_multi_controller

Interface
REQ-001 Parameter NumChannels, default 4: number of independent NeoPixel data lines driven in lockstep.
REQ-002 Parameter CounterWidth, default 16: width of every timing field.
REQ-003 Parameter NumPixelWidth, default 12: width of num_pixel_i.
REQ-004 clk_i  input  1  primary clock; all ports are synchronous to it.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 enable_i  input  1  permits starting a new frame.
REQ-007 rgbw_i  input  1  0 = 24-bit GRB pixels, 1 = 32-bit GRBW pixels.
REQ-008 num_pixel_i  input  NumPixelWidth  number of pixels per channel per frame.
REQ-009 t1h_i, t1l_i, t0h_i, t0l_i, t_latch_i, sleep_i  input  CounterWidth each  phase lengths in clk_i cycles.
REQ-010 data_i  input  NumChannels x 32  pixel word per channel, MSB-aligned; bits [7:0] are ignored in 24-bit mode.
REQ-011 valid_i  input  NumChannels  per-channel data valid.
REQ-012 ready_o  output  NumChannels  per-channel pop strobe; a transfer occurs when valid_i[c] and ready_o[c] are both high.
REQ-013 data_o  output  NumChannels  NeoPixel data lines.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 underrun_o  output  NumChannels  sticky per-channel underrun flag.
REQ-016 frame_done_o  output  1  single-cycle pulse at end of latch phase.

Function
REQ-017 FSM states: IDLE, SEND, LATCH, SLEEP.
REQ-018 IDLE->SEND when enable_i=1, num_pixel_i!=0 and all valid_i bits are high; this cycle: ready_o all high, all words loaded, config snapshot taken, underrun_o cleared.
REQ-019 Snapshot: rgbw_i, num_pixel_i and all six timing fields are registered at frame start; input changes mid-frame have no effect until the next frame.
REQ-020 Bits per pixel B = 24 (rgbw=0) or 32 (rgbw=1); bits are sent MSB first (G7..G0, R, B, then W).
REQ-021 Slot length S = max(t1h+t1l, t0h+t0l), computed at CounterWidth+1 bits without overflow; S=0 is treated as 1.
REQ-022 Slot counter runs 0..S-1; data_o[c] = 1 while counter < (current bit of c ? t1h : t0h), else 0; all channels share slot boundaries.
REQ-023 At counter==S-1: shift every channel's word left by one; advance bit index; the counter wraps to 0.
REQ-024 After bit B-1 of a pixel, if pixel index < num_pixel-1: ready_o all high for that one cycle; channels with valid_i=1 load data_i; channels with valid_i=0 load zero and set underrun_o[c]; SEND continues with no gap cycle.
REQ-025 After bit B-1 of the last pixel: SEND->LATCH with the counter cleared; data_o all 0.
REQ-026 LATCH lasts max(t_latch,1) cycles, then frame_done_o pulses for one cycle and the FSM moves to SLEEP (sleep!=0) or IDLE (sleep==0).
REQ-027 SLEEP lasts sleep cycles with data_o all 0, then moves to IDLE; a new frame cannot start during SLEEP.
REQ-028 ready_o is 0 outside the load cycles of REQ-018 and REQ-024.
REQ-029 Deasserting enable_i mid-frame does not abort the frame; it only blocks the next IDLE->SEND.
REQ-030 underrun_o[c] holds its value until the next frame start.
REQ-031 Timing fields equal to 0 give a constant-low output for that bit type; no other behaviour changes.

Reset
REQ-032 On rst_ni=0, asynchronously: state=IDLE; counters, indices and shift words=0; data_o, ready_o, busy_o, underrun_o, frame_done_o=0.
REQ-033 Reset mid-frame drops the in-flight frame; after release the FSM waits in IDLE for REQ-018 conditions.

Verification
REQ-034 NumChannels=2, rgbw=0, num_pixel=1, t1h=8, t1l=4, t0h=4, t0l=8, t_latch=50, sleep=0, words 0xFF000000/0x00000000 -> 24 slots of 12 cycles; ch0 high 8 cycles in slots 0-7 and 4 in slots 8-23; ch1 high 4 cycles in all slots; frame_done_o pulses exactly 1 cycle after 50 latch cycles.
REQ-035 rgbw=1, num_pixel=2, word 0x000000FF each -> 32 slots per pixel, last 8 slots of each pixel use t1h; exactly 2 pops per channel; no gap cycle between pixels.
REQ-036 2 pixels, ch1 valid_i low at the second load -> ch1 sends 24 zero-bits; underrun_o[1]=1, underrun_o[0]=0; underrun_o cleared at the next frame start.
REQ-037 Change t1h and num_pixel mid-frame -> current frame uses snapshotted values; next frame uses the new values.
REQ-038 sleep=20, with enable_i and valid_i held high -> busy_o stays high through 20 SLEEP cycles; next frame starts on the first IDLE cycle.
REQ-039 Assert rst_ni=0 mid-slot -> all outputs 0 in the same cycle; num_pixel_i=0 -> the FSM never leaves IDLE.
